// File: rtl/tetris_pkg.sv
// Shared state/move encodings and datapath widths for the tetris game controller.
package tetris_pkg;

  localparam int unsigned BoardW = 32;
  localparam int unsigned LocW   = 5;

  typedef enum logic [2:0] {
    StGen      = 3'd0,
    StMove     = 3'd1,
    StLand     = 3'd2,
    StClear    = 3'd3,
    StNewBoard = 3'd4,
    StGameOver = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MvNone  = 2'd0,
    MvLeft  = 2'd1,
    MvRight = 2'd2,
    MvRot   = 2'd3
  } move_e;

endpackage

// File: rtl/btn_edge.sv
// Registers one raw button level and flags its rising edge in the same cycle.
module btn_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic edge_o
);

  logic level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign edge_o = level_i & ~level_q;

endmodule

// File: rtl/tetris_ctrl.sv
// Game sequencer: tick divider, game FSM, button move buffer and registered
// feedback copies of the datapath board/location/rotation/piece.
module tetris_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clka,
  input  logic              restart,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_rotate,
  input  logic              btn_start,
  input  logic              touched,
  input  logic              error_in,
  input  logic [BoardW-1:0] dp_board,
  input  logic [LocW-1:0]   dp_location,
  input  logic [1:0]        dp_rotation,
  input  logic [1:0]        dp_piece,
  output logic [2:0]        state,
  output logic [2:0]        old_state,
  output logic [1:0]        move,
  output logic [BoardW-1:0] board_q,
  output logic [LocW-1:0]   location_q,
  output logic [1:0]        rotation_q,
  output logic [1:0]        piece_q,
  output logic              tick,
  output logic [CNT_W-1:0]  piece_count,
  output logic              game_over
);

  localparam logic [7:0] TickMax = 8'(TICK_DIV - 1);

  logic [7:0]        tick_cnt_q, tick_cnt_d;
  state_e            state_q, state_d;
  state_e            old_state_q, old_state_d;
  move_e             pend_q, pend_d;
  logic              start_q, start_d;
  logic [BoardW-1:0] board_d;
  logic [LocW-1:0]   location_d;
  logic [1:0]        rotation_d, piece_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              left_edge, right_edge, rot_edge, start_edge, start_seen;
  logic [BoardW-1:0] board_r;
  logic [LocW-1:0]   location_r;
  logic [1:0]        rotation_r, piece_r;

  btn_edge u_edge_left (
    .clk_i  (clka),
    .rst_ni (restart),
    .level_i(btn_left),
    .edge_o (left_edge)
  );

  btn_edge u_edge_right (
    .clk_i  (clka),
    .rst_ni (restart),
    .level_i(btn_right),
    .edge_o (right_edge)
  );

  btn_edge u_edge_rot (
    .clk_i  (clka),
    .rst_ni (restart),
    .level_i(btn_rotate),
    .edge_o (rot_edge)
  );

  btn_edge u_edge_start (
    .clk_i  (clka),
    .rst_ni (restart),
    .level_i(btn_start),
    .edge_o (start_edge)
  );

  assign tick       = (tick_cnt_q == TickMax);
  assign start_seen = start_q | start_edge;

  always_comb begin
    tick_cnt_d  = tick ? 8'd0 : tick_cnt_q + 8'd1;
    state_d     = state_q;
    old_state_d = old_state_q;
    pend_d      = pend_q;
    board_d     = board_r;
    location_d  = location_r;
    rotation_d  = rotation_r;
    piece_d     = piece_r;
    count_d     = count_q;
    start_d     = (state_q == StGameOver) ? start_seen : 1'b0;

    // One-deep move slot: a full slot drains on the tick, an empty one accepts
    // the highest-priority edge (including an edge landing on the tick itself).
    if (state_q != StMove) begin
      pend_d = MvNone;
    end else if (tick && (pend_q != MvNone)) begin
      pend_d = MvNone;
    end else if (pend_q == MvNone) begin
      if (rot_edge) begin
        pend_d = MvRot;
      end else if (right_edge) begin
        pend_d = MvRight;
      end else if (left_edge) begin
        pend_d = MvLeft;
      end
    end

    if (tick) begin
      old_state_d = state_q;
      case (state_q)
        StNewBoard: begin
          board_d    = '0;
          rotation_d = '0;
          piece_d    = '0;
          state_d    = StGen;
        end
        StGen: begin
          piece_d    = dp_piece;
          location_d = dp_location;
          rotation_d = dp_rotation;
          state_d    = StMove;
        end
        StMove: begin
          location_d = dp_location;
          rotation_d = dp_rotation;
          board_d    = dp_board;
          if (touched) begin
            state_d = StLand;
          end
        end
        StLand: begin
          board_d = dp_board;
          if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          state_d = StClear;
        end
        StClear: begin
          board_d = dp_board;
          state_d = error_in ? StGameOver : StGen;
        end
        StGameOver: begin
          if (start_seen) begin
            state_d = StNewBoard;
            start_d = 1'b0;
          end
        end
        default: state_d = StNewBoard;
      endcase
    end
  end

  always_ff @(posedge clka or negedge restart) begin
    if (!restart) begin
      tick_cnt_q  <= 8'd0;
      state_q     <= StNewBoard;
      old_state_q <= StNewBoard;
      pend_q      <= MvNone;
      start_q     <= 1'b0;
      board_r     <= '0;
      location_r  <= '0;
      rotation_r  <= '0;
      piece_r     <= '0;
      count_q     <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      old_state_q <= old_state_d;
      pend_q      <= pend_d;
      start_q     <= start_d;
      board_r     <= board_d;
      location_r  <= location_d;
      rotation_r  <= rotation_d;
      piece_r     <= piece_d;
      count_q     <= count_d;
    end
  end

  assign state       = state_q;
  assign old_state   = old_state_q;
  assign move        = (state_q == StMove) ? pend_q : MvNone;
  assign board_q     = board_r;
  assign location_q  = location_r;
  assign rotation_q  = rotation_r;
  assign piece_q     = piece_r;
  assign piece_count = count_q;
  assign game_over   = (state_q == StGameOver);

endmodule

// File: tb/tb_tetris_ctrl.sv
// Randomized bench for tetris_ctrl with a behavioural game model and directed anchor checks.
module tb_tetris_ctrl;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic        clka = 1'b0;
  logic        restart = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_rotate = 1'b0, btn_start = 1'b0;
  logic        touched = 1'b0, error_in = 1'b0;
  logic [31:0] dp_board = '0;
  logic [4:0]  dp_location = '0;
  logic [1:0]  dp_rotation = '0, dp_piece = '0;
  logic [2:0]  state, old_state;
  logic [1:0]  move;
  logic [31:0] board_q;
  logic [4:0]  location_q;
  logic [1:0]  rotation_q, piece_q;
  logic        tick;
  logic [CNT_W-1:0] piece_count;
  logic        game_over;

  int total = 0;
  int bad   = 0;

  tetris_ctrl #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .clka       (clka),
    .restart    (restart),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_rotate (btn_rotate),
    .btn_start  (btn_start),
    .touched    (touched),
    .error_in   (error_in),
    .dp_board   (dp_board),
    .dp_location(dp_location),
    .dp_rotation(dp_rotation),
    .dp_piece   (dp_piece),
    .state      (state),
    .old_state  (old_state),
    .move       (move),
    .board_q    (board_q),
    .location_q (location_q),
    .rotation_q (rotation_q),
    .piece_q    (piece_q),
    .tick       (tick),
    .piece_count(piece_count),
    .game_over  (game_over)
  );

  always #5 clka = ~clka;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural game model: states as plain ints (0 GEN .. 5 GAMEOVER),
  // the tick as a cycle count modulo TICK_DIV, the move slot as a small int.
  int          m_cyc, m_state, m_old, m_pend, m_count;
  logic [31:0] m_board;
  logic [4:0]  m_loc;
  logic [1:0]  m_rot, m_piece;
  bit          m_start, p_l, p_r, p_o, p_s;

  always @(posedge clka or negedge restart) begin
    if (!restart) begin
      m_cyc = 0; m_state = 4; m_old = 4; m_pend = 0; m_count = 0;
      m_board = 0; m_loc = 0; m_rot = 0; m_piece = 0;
      m_start = 0; p_l = 0; p_r = 0; p_o = 0; p_s = 0;
    end else begin
      bit t, el, er, eo, es, seen;
      t    = (m_cyc % TICK_DIV) == TICK_DIV - 1;
      el   = btn_left && !p_l;
      er   = btn_right && !p_r;
      eo   = btn_rotate && !p_o;
      es   = btn_start && !p_s;
      seen = m_start || es;
      if (m_state != 1) m_pend = 0;
      else if (t && m_pend != 0) m_pend = 0;
      else if (m_pend == 0) m_pend = eo ? 3 : (er ? 2 : (el ? 1 : 0));
      m_start = (m_state == 5) ? seen : 0;
      if (t) begin
        m_old = m_state;
        case (m_state)
          4: begin m_board = 0; m_rot = 0; m_piece = 0; m_state = 0; end
          0: begin m_piece = dp_piece; m_loc = dp_location; m_rot = dp_rotation; m_state = 1; end
          1: begin
            m_loc = dp_location; m_rot = dp_rotation; m_board = dp_board;
            if (touched) m_state = 2;
          end
          2: begin
            m_board = dp_board;
            if (m_count < CNT_MAX) m_count++;
            m_state = 3;
          end
          3: begin m_board = dp_board; m_state = error_in ? 5 : 0; end
          5: if (seen) begin m_state = 4; m_start = 0; end
          default: m_state = 4;
        endcase
      end
      m_cyc++;
      p_l = btn_left; p_r = btn_right; p_o = btn_rotate; p_s = btn_start;
    end
  end

  always @(negedge clka) begin
    if (restart) begin
      chk("state", state, m_state);
      chk("old_state", old_state, m_old);
      chk("move", move, (m_state == 1) ? m_pend : 0);
      chk("board_q", board_q, m_board);
      chk("location_q", location_q, m_loc);
      chk("rotation_q", rotation_q, m_rot);
      chk("piece_q", piece_q, m_piece);
      chk("tick", tick, ((m_cyc % TICK_DIV) == TICK_DIV - 1));
      chk("piece_count", piece_count, m_count);
      chk("game_over", game_over, m_state == 5);
    end
  end

  // Step to the next tick cycle (bounded), then to the negedge just after it.
  task automatic next_tick();
    int n = 0;
    do begin
      @(negedge clka);
      n++;
    end while (!tick && n < 4 * TICK_DIV);
    chk("tick_seen", tick, 1);
    @(negedge clka);
  endtask

  task automatic async_reset_check();
    @(posedge clka);
    #2 restart = 1'b0;
    #1;
    chk("rst_state", state, 4);
    chk("rst_old_state", old_state, 4);
    chk("rst_board", board_q, 0);
    chk("rst_location", location_q, 0);
    chk("rst_count", piece_count, 0);
    chk("rst_move", move, 0);
    chk("rst_tick", tick, 0);
    chk("rst_game_over", game_over, 0);
    @(negedge clka);
    restart = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clka);
    chk("reset_state", state, 4);
    chk("reset_board", board_q, 0);
    chk("reset_tick", tick, 0);
    restart = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clka);
      chk("tick_phase", tick, (i == 3));
    end
    @(negedge clka);
    chk("nb_to_gen", state, 0);
    chk("nb_board", board_q, 0);

    dp_piece = 2; dp_location = 5; dp_rotation = 1;
    next_tick();
    chk("gen_piece", piece_q, 2);
    chk("gen_location", location_q, 5);
    chk("gen_rotation", rotation_q, 1);
    chk("gen_state", state, 1);
    chk("gen_old_state", old_state, 0);

    btn_left = 1; btn_rotate = 1;
    @(negedge clka);
    chk("move_rot_wins", move, 3);
    next_tick();
    chk("move_consumed", move, 0);
    next_tick();
    chk("move_held_none", move, 0);
    btn_left = 0; btn_rotate = 0;

    touched = 1; dp_board = 32'h000F_0000;
    next_tick();
    chk("land_state", state, 2);
    touched = 0;
    next_tick();
    chk("land_board", board_q, 32'h000F_0000);
    chk("land_count", piece_count, 1);
    chk("clear_state", state, 3);

    error_in = 1;
    next_tick();
    chk("gameover_state", state, 5);
    chk("gameover_flag", game_over, 1);
    error_in = 0;
    btn_start = 1;
    @(negedge clka);
    btn_start = 0;
    next_tick();
    chk("restart_state", state, 4);
    next_tick();
    chk("newboard_board", board_q, 0);
    chk("newboard_to_gen", state, 0);
    next_tick();
    chk("mid_move_state", state, 1);
    async_reset_check();

    for (int c = 0; c < 3000; c++) begin
      @(negedge clka);
      if ($urandom_range(3) == 0) btn_left = ~btn_left;
      if ($urandom_range(3) == 0) btn_right = ~btn_right;
      if ($urandom_range(3) == 0) btn_rotate = ~btn_rotate;
      if ($urandom_range(5) == 0) btn_start = ~btn_start;
      touched     = ($urandom_range(2) == 0);
      error_in    = ($urandom_range(3) == 0);
      dp_board    = $urandom;
      dp_location = 5'($urandom);
      dp_rotation = 2'($urandom);
      dp_piece    = 2'($urandom);
      if (c == 1500) async_reset_check();
    end

    btn_left = 0; btn_right = 0; btn_rotate = 0; btn_start = 0;
    async_reset_check();
    touched = 1; error_in = 0;
    for (int c = 0; c < 4400; c++) begin
      @(negedge clka);
      dp_board = $urandom;
    end
    chk("count_saturated", piece_count, CNT_MAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
